mac_window_accum: RTL

//  Downstream stage of the 16-bit multiply-accumulate stage (result = a*b + c).

---
 rtl/mac_window_accum.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mac_window_accum.sv
// mac_window_accum
//  Sums consecutive unsigned MAC results over a window of WIN_LEN samples and
//  presents each window total on a one-entry valid/ready output buffer. A
//  flush closes a partial window early; an empty window never produces a
//  result.
//
//  Optional feature macro: MAC_ACCUM_AVG_EN
//    defined   -> sum_out carries the window sum >> $clog2(WIN_LEN)
//                 (WIN_LEN must be a power of two)
//    undefined -> sum_out carries the raw window sum
//
//  Ports
//    clk        in   1       clock, all logic on posedge
//    reset      in   1       synchronous reset, active-high
//    in_data    in   DATA_W  MAC result (unsigned)
//    in_valid   in   1       in_data valid
//    in_ready   out  1       stage accepts in_data this cycle
//    flush      in   1       close the current (partial) window
//    sum_out    out  ACC_W   window total (or mean in the averaging build)
//    sum_count  out  CNT_W   number of samples in the emitted window
//    sum_valid  out  1       sum_out/sum_count valid
//    sum_ready  in   1       downstream accepts the result
module mac_window_accum #(
  parameter int DATA_W  = 16,
  parameter int WIN_LEN = 8,
  parameter int CNT_W   = $clog2(WIN_LEN + 1),
  parameter int ACC_W   = DATA_W + $clog2(WIN_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [ACC_W-1:0]  sum_out,
  output logic [CNT_W-1:0]  sum_count,
  output logic              sum_valid,
  input  logic              sum_ready
);

  // Elaboration-time sanity checks on the window length.
  if (WIN_LEN < 2) begin : g_bad_win_len
    $error("mac_window_accum: WIN_LEN must be >= 2");
  end

`ifdef MAC_ACCUM_AVG_EN
  if ((WIN_LEN & (WIN_LEN - 1)) != 0) begin : g_bad_avg_len
    $error("mac_window_accum: WIN_LEN must be a power of two when averaging");
  end
  localparam int SHIFT = $clog2(WIN_LEN);
`endif

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               xfer;
  logic               close_win;
  logic [CNT_W-1:0]   eff_cnt;
  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W-1:0]   result;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    count_d   = count_q;

    xfer      = in_valid && (state_q == ST_ACCUM);
    // Count and sum as they will stand once this cycle's sample (if any) is in.
    eff_cnt   = cnt_q + CNT_W'(xfer);
    acc_next  = xfer ? (acc_q + ACC_W'(in_data)) : acc_q;

    // A window closes when the last slot fills, or on flush provided it
    // would not produce an empty result. Flush is meaningless while holding.
    close_win = (state_q == ST_ACCUM) &&
                ((xfer && (cnt_q == CNT_W'(WIN_LEN - 1))) ||
                 (flush && (eff_cnt != '0)));

`ifdef MAC_ACCUM_AVG_EN
    // Partial windows are still divided by WIN_LEN; consumers rescale
    // using sum_count.
    result    = acc_next >> SHIFT;
`else
    result    = acc_next;
`endif

    case (state_q)
      ST_ACCUM: begin
        if (close_win) begin
          sum_d   = result;
          count_d = eff_cnt;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          acc_d   = acc_next;
          cnt_d   = eff_cnt;
        end
      end
      ST_HOLD: begin
        // No bypass: the stage reopens for input only on the next cycle.
        if (sum_ready) begin
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign sum_valid = (state_q == ST_HOLD);
  assign sum_out   = sum_q;
  assign sum_count = count_q;

endmodule
